if_fetch_buf: RTL and testbench

//  Instruction-fetch front end between the PC source and the IF/ID pipeline register.
//  - Generates the fetch PC and drives the combinational instruction ROM (ce/addr in, inst back in the same cycle).
//  - Queues fetched {pc, inst} pairs in a small prefetch FIFO so ID stalls do not lose fetched words.
//  - Performs branch redirects that honour the MIPS delay slot, and exception flushes.

---
 rtl/if_fetch_buf_pkg.sv | 37 +++
 rtl/if_fetch_buf_if.sv | 38 +++
 rtl/if_fetch_buf_fifo.sv | 85 ++++++++
 rtl/if_fetch_buf.sv | 122 ++++++++++++
 tb/tb_if_fetch_buf.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_buf_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_buf_pkg
// Shared types and constants for the instruction-fetch front end.
//   - Bus widths and the ZERO_WORD / chip-enable encodings used on the ROM side.
//   - The fetch state machine encoding (RUN / DS_WAIT).
//   - The {pc, inst} entry stored in the prefetch FIFO.
//   - next_seq_pc(): sequential fetch address (wraps modulo 2^32).
// -----------------------------------------------------------------------------
package if_fetch_buf_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD        = '0;
  localparam logic                   CHIP_ENABLE      = 1'b1;
  localparam logic                   CHIP_DISABLE     = 1'b0;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] PC_STEP          = 32'd4;

  // RUN: normal sequential fetch. DS_WAIT: a taken branch arrived before its
  // delay slot was fetched; fetch the delay slot, then jump to the saved target.
  typedef enum logic {
    IF_ST_RUN     = 1'b0,
    IF_ST_DS_WAIT = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Plain 32-bit add: FFFFFFFC + 4 wraps to 00000000.
  function automatic logic [INST_ADDR_W-1:0] next_seq_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage : if_fetch_buf_pkg

// File: rtl/if_fetch_buf_if.sv
// -----------------------------------------------------------------------------
// if_fetch_buf_if
// Bundles the fetch front end's control, ROM and output signals.
//   Control in : stall, flush, new_pc, branch_flag, branch_target
//   ROM        : rom_ce, rom_addr (out of the fetch unit), rom_inst (back in,
//                combinational, same cycle)
//   Output     : out_valid, out_pc, out_inst (FIFO head toward IF/ID)
// Modports:
//   master - the fetch unit (if_fetch_buf)
//   slave  - its environment (pipeline control, ROM model, IF/ID register)
// -----------------------------------------------------------------------------
interface if_fetch_buf_if;

  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;

  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    input  stall, flush, new_pc, branch_flag, branch_target, rom_inst,
    output rom_ce, rom_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output stall, flush, new_pc, branch_flag, branch_target, rom_inst,
    input  rom_ce, rom_addr, out_valid, out_pc, out_inst
  );

endinterface : if_fetch_buf_if

// File: rtl/if_fetch_buf_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_buf_fifo
// Prefetch FIFO of {pc, inst} entries (64 bits each), DEPTH entries deep.
// DEPTH must be a power of two >= 2 so the pointer wrap is a natural overflow.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset (empties the FIFO)
//   push_i   in   write wdata_i at the tail (ignored when full unless popping)
//   pop_i    in   drop the head (ignored when empty)
//   clear_i  in   discard every entry; overrides push and pop
//   wdata_i  in   entry to write
//   rdata_o  out  head entry (meaningful only when !empty_o)
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
// -----------------------------------------------------------------------------
module if_fetch_buf_fifo
  import if_fetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit distinguishes full from empty when the index bits match.
  typedef logic [AW:0] ptr_t;

  fetch_entry_t mem_q [DEPTH];
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A simultaneous pop frees the slot a full FIFO needs for the push.
  assign do_pop  = pop_i  & ~empty_o & ~clear_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned (which would infer a latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      // Collapse to empty at the current read position.
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule : if_fetch_buf_fifo

// File: rtl/if_fetch_buf.sv
// -----------------------------------------------------------------------------
// if_fetch_buf
// Instruction-fetch front end between the PC source and the IF/ID register.
// Drives a combinational instruction ROM, queues fetched {pc, inst} pairs in a
// prefetch FIFO so ID stalls lose nothing, and performs branch redirects that
// honour the MIPS delay slot plus exception flushes (flush > branch).
// Parameters:
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-low reset
//   bus   if   if_fetch_buf_if.master: control inputs, ROM ce/addr/inst,
//              FIFO head outputs (out_valid/out_pc/out_inst)
// -----------------------------------------------------------------------------
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_buf_if.master bus
);

  if_state_e    state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         rom_ce_q;

  logic         push;
  logic         pop;
  logic         clear;
  logic         fifo_full;
  logic         fifo_empty;
  logic         head_valid;
  logic         branch_take;
  logic         has_room;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign head_valid  = ~fifo_empty;
  assign pop         = head_valid & ~bus.stall;
  assign has_room    = ~fifo_full | pop;
  // A branch is only honoured in RUN and only while ID is not stalled.
  assign branch_take = (state_q == IF_ST_RUN) & bus.branch_flag & ~bus.stall;
  assign wr_entry    = '{pc: pc_q, inst: bus.rom_inst};

  // Next-state / redirect decode, in priority order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    push    = 1'b0;
    clear   = 1'b0;

    if (bus.flush) begin
      // Exception: drop everything, including a pending branch target.
      clear   = 1'b1;
      pc_d    = bus.new_pc;
      state_d = IF_ST_RUN;
    end else if (state_q == IF_ST_DS_WAIT) begin
      // pc already points at the delay slot; fetch it, then jump.
      push = rom_ce_q & has_room;
      if (push) begin
        pc_d    = tgt_q;
        state_d = IF_ST_RUN;
      end
    end else if (branch_take && head_valid) begin
      // The head is the delay slot and is consumed this cycle; everything
      // behind it is on the wrong path, so clearing empties the FIFO exactly.
      clear = 1'b1;
      pc_d  = bus.branch_target;
    end else if (branch_take) begin
      // Delay slot not fetched yet: pc (= branch PC + 4) holds.
      tgt_d   = bus.branch_target;
      state_d = IF_ST_DS_WAIT;
    end else begin
      // Sequential fetch. When full and not popping the ROM read is simply
      // discarded and pc holds.
      push = rom_ce_q & has_room;
      if (push) pc_d = next_seq_pc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IF_ST_RUN;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      rom_ce_q <= CHIP_DISABLE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      // Enable rises on the first edge out of reset; first fetch one cycle later.
      rom_ce_q <= CHIP_ENABLE;
    end
  end

  if_fetch_buf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.rom_ce    = rom_ce_q;
  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head_valid ? head.pc   : ZERO_WORD;
  assign bus.out_inst  = head_valid ? head.inst : ZERO_WORD;

endmodule : if_fetch_buf

// File: tb/tb_if_fetch_buf.sv
module tb_if_fetch_buf;
  import if_fetch_buf_pkg::*;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  if_fetch_buf_if bus ();
  if_fetch_buf_if bus_w ();

  // ROM contents: a scrambled function of the address, never zero at 0.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb bus.rom_inst   = rom_fn(bus.rom_addr);
  always_comb bus_w.rom_inst = rom_fn(bus_w.rom_addr);

  if_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  if_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
    .clk (clk), .rst (rst_w), .bus (bus_w)
  );

  // Reference model: the prefetch queue as a list of PCs plus the fetch address.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_ce;
  bit          m_ds;   // taken branch waiting for its delay slot

  task automatic model_update(input bit r, input bit s, input bit f,
                              input logic [31:0] npc, input bit b, input logic [31:0] bt);
    bit valid;
    bit pop;
    if (!r) begin
      m_q.delete(); m_pc = RESET_PC; m_ce = 0; m_ds = 0;
      return;
    end
    valid = (m_q.size() != 0);
    pop   = valid && !s;
    if (f) begin
      m_q.delete(); m_pc = npc; m_ds = 0;
    end else if (m_ds) begin
      if (pop) void'(m_q.pop_front());
      if (m_ce && m_q.size() < DEPTH) begin
        m_q.push_back(m_pc); m_pc = m_tgt; m_ds = 0;
      end
    end else if (b && !s) begin
      if (valid) begin
        m_q.delete(); m_pc = bt;          // delay slot leaves, wrong path dropped
      end else begin
        m_tgt = bt; m_ds = 1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_ce && m_q.size() < DEPTH) begin
        m_q.push_back(m_pc); m_pc = m_pc + 32'd4;
      end
    end
    m_ce = 1;
  endtask

  // Drive one cycle of inputs (called at negedge), advance to the next negedge.
  task automatic tick(input bit r, input bit s, input bit f,
                      input logic [31:0] npc, input bit b, input logic [31:0] bt);
    rst = r;
    bus.stall = s; bus.flush = f; bus.new_pc = npc;
    bus.branch_flag = b; bus.branch_target = bt;
    model_update(r, s, f, npc, b, bt);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.rom_ce !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d rom_ce=%b out_valid=%b expected 0/0", i, bus.rom_ce, bus.out_valid);
      end
    end
    checks++;
    if (bus.out_pc !== 32'h0 || bus.out_inst !== ZERO_WORD) begin
      errors++;
      $display("FAIL reset_outs out_pc=%h out_inst=%h expected 0/0", bus.out_pc, bus.out_inst);
    end
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rom_ce !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rom_ce=%b out_valid=%b expected 1/0", bus.rom_ce, bus.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i] || bus.out_inst !== rom_fn(exp_pc[i])) begin
        errors++;
        $display("FAIL reset_seq%0d valid=%b pc=%h inst=%h expected 1/%h/%h",
                 i, bus.out_valid, bus.out_pc, bus.out_inst, exp_pc[i], rom_fn(exp_pc[i]));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'hC, 32'h10, 32'h14};
    do_reset();
    repeat (3) tick(1, 0, 0, 0, 0, 0);     // head now at 8
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 0, 0, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8) begin
        errors++;
        $display("FAIL stall_hold%0d valid=%b pc=%h expected 1/8", i, bus.out_valid, bus.out_pc);
      end
    end
    checks++;
    if (bus.rom_addr !== 32'h10 || bus.rom_ce !== 1'b1) begin
      errors++;
      $display("FAIL stall_pc rom_addr=%h rom_ce=%b expected 10/1", bus.rom_addr, bus.rom_ce);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL stall_release%0d valid=%b pc=%h expected 1/%h", i, bus.out_valid, bus.out_pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch_head();
    do_reset();
    repeat (4) tick(1, 0, 0, 0, 0, 0);     // head now at C
    checks++;
    if (bus.out_pc !== 32'hC) begin
      errors++;
      $display("FAIL bhead_pre pc=%h expected C", bus.out_pc);
    end
    tick(1, 0, 0, 0, 1, 32'h100);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h100) begin
      errors++;
      $display("FAIL bhead_redirect valid=%b rom_addr=%h expected 0/100", bus.out_valid, bus.rom_addr);
    end
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin
      errors++;
      $display("FAIL bhead_target valid=%b pc=%h expected 1/100", bus.out_valid, bus.out_pc);
    end
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out_pc !== 32'h104) begin
      errors++;
      $display("FAIL bhead_next pc=%h expected 104", bus.out_pc);
    end
  endtask

  task automatic test_branch_empty();
    tick(1, 0, 1, 32'h40, 0, 0);          // empty FIFO, pc=40
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h40) begin
      errors++;
      $display("FAIL bempty_setup valid=%b rom_addr=%h expected 0/40", bus.out_valid, bus.rom_addr);
    end
    tick(1, 0, 0, 0, 1, 32'h200);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h40) begin
      errors++;
      $display("FAIL bempty_wait valid=%b rom_addr=%h expected 0/40", bus.out_valid, bus.rom_addr);
    end
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.rom_addr !== 32'h200) begin
      errors++;
      $display("FAIL bempty_slot valid=%b pc=%h rom_addr=%h expected 1/40/200", bus.out_valid, bus.out_pc, bus.rom_addr);
    end
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin
      errors++;
      $display("FAIL bempty_target valid=%b pc=%h expected 1/200", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_flush_vs_branch();
    tick(1, 0, 1, 32'h180, 1, 32'h300);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 32'h180) begin
      errors++;
      $display("FAIL flush_clear valid=%b rom_addr=%h expected 0/180", bus.out_valid, bus.rom_addr);
    end
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h180) begin
      errors++;
      $display("FAIL flush_target valid=%b pc=%h expected 1/180", bus.out_valid, bus.out_pc);
    end
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out_pc !== 32'h184) begin
      errors++;
      $display("FAIL flush_next pc=%h expected 184", bus.out_pc);
    end
  endtask

  task automatic test_random();
    bit          r, s, f, b;
    logic [31:0] npc, bt;
    bit          e_valid;
    logic [31:0] e_pc, e_inst;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      s   = ($urandom_range(0, 99) < 35);
      f   = ($urandom_range(0, 99) < 3);
      b   = ($urandom_range(0, 99) < 12);
      npc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      bt  = $urandom();
      tick(r, s, f, npc, b, bt);
      e_valid = (m_q.size() != 0);
      e_pc    = e_valid ? m_q[0] : 32'h0;
      e_inst  = e_valid ? rom_fn(m_q[0]) : ZERO_WORD;
      checks++;
      if (bus.rom_ce !== m_ce || bus.rom_addr !== m_pc) begin
        errors++;
        $display("FAIL rand_rom cyc%0d rom_ce=%b rom_addr=%h expected %b/%h", i, bus.rom_ce, bus.rom_addr, m_ce, m_pc);
      end
      checks++;
      if (bus.out_valid !== e_valid || bus.out_pc !== e_pc || bus.out_inst !== e_inst) begin
        errors++;
        $display("FAIL rand_out cyc%0d valid=%b pc=%h inst=%h expected %b/%h/%h",
                 i, bus.out_valid, bus.out_pc, bus.out_inst, e_valid, e_pc, e_inst);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    rst_w = 1'b0;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    rst_w = 1'b1;
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus_w.rom_ce !== 1'b1 || bus_w.rom_addr !== WRAP_PC || bus_w.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_release rom_ce=%b rom_addr=%h valid=%b expected 1/%h/0",
               bus_w.rom_ce, bus_w.rom_addr, bus_w.out_valid, WRAP_PC);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      checks++;
      if (bus_w.out_valid !== 1'b1 || bus_w.out_pc !== exp_pc[i] || bus_w.out_inst !== rom_fn(exp_pc[i])) begin
        errors++;
        $display("FAIL wrap_seq%0d valid=%b pc=%h inst=%h expected 1/%h/%h",
                 i, bus_w.out_valid, bus_w.out_pc, bus_w.out_inst, exp_pc[i], rom_fn(exp_pc[i]));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    rst_w = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.new_pc = '0;
    bus.branch_flag = 1'b0; bus.branch_target = '0;
    bus_w.stall = 1'b0; bus_w.flush = 1'b0; bus_w.new_pc = '0;
    bus_w.branch_flag = 1'b0; bus_w.branch_target = '0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_branch_head();
    test_branch_empty();
    test_flush_vs_branch();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_if_fetch_buf
